wb_write_arbiter: RTL and testbench

- Sole driver of the register file write port (we3/wa3/wd3).
- Merges two write sources onto that single port:
  - the in-order pipeline writeback stage, which has priority and cannot stall;
  - a long-latency unit (multiply/divide results), which uses a valid/ready handshake and is buffered in a small FIFO.
- Provides pending-write flags and a starvation request so the hazard unit can stall dependent instructions or insert a writeback bubble.

---
 rtl/wb_write_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_write_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Sole driver of the register-file write port: merges the non-stallable pipeline
// writeback with a FIFO-buffered long-latency result stream, pipeline first.
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_wa,
  input  logic [31:0]              pipe_wd,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_wa,
  input  logic [31:0]              lu_wd,
  input  logic [4:0]               ra1,
  input  logic [4:0]               ra2,
  output logic                     pend1,
  output logic                     pend2,
  output logic                     wb_hold,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [31:0]              wd3
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          wb_hold_q;
  logic          we3_q;
  logic [4:0]    wa3_q;
  logic [31:0]   wd3_q;

  logic          pipe_act;
  logic          fifo_nonempty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [DEPTH-1:0] ent_valid, hit1, hit2;

  assign pipe_act      = pipe_we && (pipe_wa != 5'd0);
  assign fifo_nonempty = (count_q != '0);
  // Readiness depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign lu_ready      = !rst && (count_q != CW'(DEPTH));
  assign accept        = lu_valid && lu_ready;
  assign push          = accept && (lu_wa != 5'd0);
  assign pop           = !pipe_act && fifo_nonempty;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] offs;
      assign offs          = AW'(gi) - rd_ptr_q;
      assign ent_valid[gi] = ({1'b0, offs} < count_q);
      assign hit1[gi]      = ent_valid[gi] && (addr_mem[gi] == ra1);
      assign hit2[gi]      = ent_valid[gi] && (addr_mem[gi] == ra2);
    end
  endgenerate

  assign pend1 = (ra1 != 5'd0) && ((|hit1) || (accept && (lu_wa == ra1)));
  assign pend2 = (ra2 != 5'd0) && ((|hit2) || (accept && (lu_wa == ra2)));

  always_comb begin
    starve_d = '0;
    if (fifo_nonempty && pipe_act) begin
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= lu_wa;
      data_mem[wr_ptr_q] <= lu_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      wb_hold_q <= 1'b0;
      we3_q     <= 1'b0;
      wa3_q     <= 5'd0;
      wd3_q     <= 32'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      starve_q  <= starve_d;
      wb_hold_q <= (starve_d == SW'(STARVE_LIMIT));
      if (pipe_act) begin
        we3_q <= 1'b1;
        wa3_q <= pipe_wa;
        wd3_q <= pipe_wd;
      end else if (fifo_nonempty) begin
        we3_q <= 1'b1;
        wa3_q <= addr_mem[rd_ptr_q];
        wd3_q <= data_mem[rd_ptr_q];
      end else begin
        we3_q <= 1'b0;
      end
    end
  end

  assign fifo_count = count_q;
  assign wb_hold    = wb_hold_q;
  assign we3        = we3_q;
  assign wa3        = wa3_q;
  assign wd3        = wd3_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: a queue-level model predicts every register
// file write and every status output; a negedge monitor retires predicted writes.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd;
  logic [4:0]  ra1, ra2;
  logic        pend1, pend2, wb_hold;
  logic [2:0]  fifo_count;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd),
    .ra1(ra1), .ra2(ra2), .pend1(pend1), .pend2(pend2),
    .wb_hold(wb_hold), .fifo_count(fifo_count),
    .we3(we3), .wa3(wa3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  wr_t mq[$];     // model FIFO contents
  wr_t expq[$];   // predicted register-file writes, oldest first
  int  starve_m;
  bit  hold_m;
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_model(input logic [4:0] a);
    foreach (mq[i]) if (mq[i].wa == a) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got r%0d=%h, expected no write", wa3, wd3);
      end else begin
        wr_t e;
        e = expq.pop_front();
        $display("write r%0d = %h (expected r%0d = %h)", wa3, wd3, e.wa, e.wd);
        chk("wa3", {27'd0, wa3}, {27'd0, e.wa});
        chk("wd3", wd3, e.wd);
      end
    end
  end

  // One clock of stimulus; returns whether the model saw the handshake accepted.
  task automatic step(input bit r, input bit pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                      input bit lv, input logic [4:0] lwa, input logic [31:0] lwd,
                      input logic [4:0] a1, input logic [4:0] a2, output bit acc);
    bit exp_ready, nonempty, pact, p1, p2;
    rst = r; pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd;
    lu_valid = lv; lu_wa = lwa; lu_wd = lwd; ra1 = a1; ra2 = a2;
    #1;
    exp_ready = !r && (mq.size() != DEPTH);
    acc = lv && exp_ready;
    p1 = (a1 != 0) && (in_model(a1) || (acc && lwa == a1));
    p2 = (a2 != 0) && (in_model(a2) || (acc && lwa == a2));
    chk("lu_ready", {31'd0, lu_ready}, {31'd0, exp_ready});
    chk("fifo_count", {29'd0, fifo_count}, mq.size());
    chk("pend1", {31'd0, pend1}, {31'd0, p1});
    chk("pend2", {31'd0, pend2}, {31'd0, p2});
    chk("wb_hold", {31'd0, wb_hold}, {31'd0, hold_m});
    if (r) begin
      mq.delete();
      starve_m = 0;
      hold_m = 1'b0;
    end else begin
      nonempty = (mq.size() != 0);
      pact = pwe && (pwa != 0);
      if (pact) expq.push_back('{pwa, pwd});
      else if (nonempty) expq.push_back(mq.pop_front());
      if (acc && lwa != 0) mq.push_back('{lwa, lwd});
      starve_m = (nonempty && pact) ? ((starve_m + 1 > LIMIT) ? LIMIT : starve_m + 1) : 0;
      hold_m = (starve_m == LIMIT);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    int k;
    bit lv_r;
    logic [4:0]  lwa_r;
    logic [31:0] lwd_r;

    rst = 1'b1; pipe_we = 1'b0; pipe_wa = 5'd0; pipe_wd = 32'd0;
    lu_valid = 1'b1; lu_wa = 5'd3; lu_wd = 32'h33; ra1 = 5'd0; ra2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we3", {31'd0, we3}, 32'd0);
    chk("rst_wa3", {27'd0, wa3}, 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
    chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_wb_hold", {31'd0, wb_hold}, 32'd0);
    mq.delete(); expq.delete(); starve_m = 0; hold_m = 1'b0;

    // Priority: pipeline write wins, long-latency result follows.
    step(0, 1, 5'd5, 32'hAAAA0005, 1, 5'd7, 32'h77, 0, 0, acc);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 7, 0, acc);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, acc);

    // Full / back-pressure: five results against a busy pipeline, then drain.
    k = 1;
    repeat (6) begin
      step(0, 1, 5'd20, 32'h2000 + k, k <= 5, 5'(k), 32'h100 + k, 5'(k), 5'd5, acc);
      if (acc) k++;
    end
    repeat (7) begin
      step(0, 0, 5'd0, 32'd0, k <= 5, 5'(k), 32'h100 + k, 5'd4, 5'd5, acc);
      if (acc) k++;
    end

    // Pending flags, then a dropped r0 result.
    step(0, 0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 9, 0, acc);
    step(0, 1, 5'd3, 32'h3, 0, 5'd0, 32'd0, 9, 0, acc);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 9, 0, acc);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 9, 0, acc);
    step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hDEAD, 0, 0, acc);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, acc);

    // Starvation: one queued entry blocked until wb_hold, then a bubble.
    step(0, 1, 5'd11, 32'hB0, 1, 5'd12, 32'hC0, 12, 0, acc);
    repeat (LIMIT + 2) step(0, 1, 5'd11, $urandom, 0, 5'd0, 32'd0, 12, 0, acc);
    repeat (3) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 12, 0, acc);

    // Stream with pipeline idle: push and pop every cycle across pointer wrap.
    for (int i = 0; i < 20; i++)
      step(0, 0, 5'd0, 32'd0, 1, 5'((i % 31) + 1), $urandom, 5'((i % 31) + 1), 0, acc);
    repeat (2) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, acc);

    // Randomized traffic with a reset in the middle.
    lv_r = 1'b0; lwa_r = 5'd0; lwd_r = 32'd0;
    for (int c = 0; c < 500; c++) begin
      bit pwe;
      bit r;
      r = (c == 250) || (c == 251);
      pwe = !hold_m && ($urandom_range(0, 99) < 60);
      if (!lv_r) begin
        lv_r  = ($urandom_range(0, 99) < 50);
        lwa_r = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        lwd_r = $urandom;
      end
      step(r, pwe, 5'($urandom_range(0, 31)), $urandom, lv_r, lwa_r, lwd_r,
           5'($urandom_range(0, 31)), lwa_r, acc);
      if (acc || r) lv_r = 1'b0;
    end

    repeat (DEPTH + 4) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, acc);
    chk("writes_outstanding", expq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
